// File: rtl/dma_priority_arbiter_if.sv
// Channel-request / host-hold bundle between the DMA register file,
// the host bus interface and the channel arbiter.
interface dma_priority_arbiter_if #(
  parameter int NUM_CH = 4
);
  logic [NUM_CH-1:0] dreq;
  logic              dreq_sense;
  logic              dack_sense;
  logic              rotating_pri;
  logic              ctrl_disable;
  logic [NUM_CH-1:0] mask;
  logic [NUM_CH-1:0] sw_req;
  logic              hlda;
  logic              xfer_done;
  logic              hrq;
  logic [NUM_CH-1:0] dack;
  logic              grant_valid;
  logic [1:0]        grant_ch;
  logic [NUM_CH-1:0] sw_clr;

  modport master (
    output dreq, dreq_sense, dack_sense, rotating_pri,
    output ctrl_disable, mask, sw_req, hlda, xfer_done,
    input  hrq, dack, grant_valid, grant_ch, sw_clr
  );

  modport slave (
    input  dreq, dreq_sense, dack_sense, rotating_pri,
    input  ctrl_disable, mask, sw_req, hlda, xfer_done,
    output hrq, dack, grant_valid, grant_ch, sw_clr
  );
endinterface

// File: rtl/dma_priority_arbiter.sv
// 8237A-style channel arbiter: fixed/rotating priority pick plus
// the HRQ/HLDA hold handshake that hands one channel to the timing FSM.
module dma_priority_arbiter #(
  parameter int NUM_CH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  dma_priority_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    GRANT
  } state_t;

  state_t            state;
  logic [1:0]        pri_ptr;
  logic [NUM_CH-1:0] dreq_q;
  logic [1:0]        grant_ch;
  logic              hrq;
  logic              grant_valid;
  logic [NUM_CH-1:0] sw_clr;

  logic [NUM_CH-1:0] pending;
  logic [NUM_CH-1:0] grant_oh;
  logic [1:0]        ptr_eff;
  logic [1:0]        winner;

  // Scan from the far end so the channel nearest ptr wins last.
  function automatic logic [1:0] pick(
    input logic [NUM_CH-1:0] p,
    input logic [1:0]        ptr
  );
    logic [1:0] c;
    pick = ptr;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      c = ptr + 2'(i);
      if (p[c]) pick = c;
    end
  endfunction

  always_comb begin
    pending  = (dreq_q & ~bus.mask) | bus.sw_req;
    ptr_eff  = bus.rotating_pri ? pri_ptr : 2'd0;
    winner   = pick(pending, ptr_eff);
    grant_oh = NUM_CH'(1) << grant_ch;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      pri_ptr     <= 2'd0;
      dreq_q      <= '0;
      grant_ch    <= 2'd0;
      hrq         <= 1'b0;
      grant_valid <= 1'b0;
      sw_clr      <= '0;
    end else begin
      dreq_q <= bus.dreq ^ {NUM_CH{bus.dreq_sense}};
      sw_clr <= '0;
      if (!bus.rotating_pri) pri_ptr <= 2'd0;
      unique case (state)
        IDLE: begin
          hrq         <= 1'b0;
          grant_valid <= 1'b0;
          if ((|pending) && !bus.ctrl_disable && !bus.hlda) begin
            grant_ch <= winner;
            hrq      <= 1'b1;
            state    <= REQ;
          end
        end
        REQ: begin
          if (!(|pending) || bus.ctrl_disable) begin
            hrq   <= 1'b0;
            state <= IDLE;
          end else if (bus.hlda) begin
            grant_valid <= 1'b1;
            state       <= GRANT;
          end else begin
            grant_ch <= winner;
          end
        end
        GRANT: begin
          if (bus.xfer_done) begin
            hrq         <= 1'b0;
            grant_valid <= 1'b0;
            sw_clr      <= grant_oh;
            if (bus.rotating_pri) pri_ptr <= grant_ch + 2'd1;
            state       <= IDLE;
          end else if (!bus.hlda) begin
            hrq         <= 1'b0;
            grant_valid <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.hrq         = hrq;
  assign bus.grant_valid = grant_valid;
  assign bus.grant_ch    = grant_ch;
  assign bus.sw_clr      = sw_clr;
  assign bus.dack        = (grant_oh & {NUM_CH{grant_valid}})
                         ^ {NUM_CH{~bus.dack_sense}};

endmodule

// File: tb/tb_dma_priority_arbiter.sv
// Scoreboard bench for dma_priority_arbiter: directed request patterns,
// expected grants and sw_clr pulses queued, checked by a monitor.
module tb_dma_priority_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  dma_priority_arbiter_if ifc ();

  dma_priority_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc)
  );

  typedef struct {
    bit         is_sw;
    logic [1:0] ch;
    logic [3:0] val;
  } ev_t;

  ev_t exp_q[$];
  int  total = 0;
  int  bad = 0;
  bit  auto_hlda = 1'b1;
  bit  man_hlda = 1'b0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Host model: returns hlda one sample after hrq unless overridden.
  initial begin
    ifc.hlda = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      ifc.hlda = auto_hlda ? ifc.hrq : man_hlda;
    end
  end

  // Monitor: every grant start and every sw_clr pulse pops one entry.
  initial begin
    bit  gv_prev;
    ev_t e;
    gv_prev = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (ifc.grant_valid && !gv_prev) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_grant actual_ch=%0d required=none",
                   ifc.grant_ch);
        end else begin
          e = exp_q.pop_front();
          chk("grant_kind", 32'd0, 32'(e.is_sw));
          chk("grant_ch", ifc.grant_ch, e.ch);
          chk("grant_dack", ifc.dack, e.val);
        end
      end
      if (ifc.sw_clr != 4'd0) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_sw_clr actual=%0h required=none",
                   ifc.sw_clr);
        end else begin
          e = exp_q.pop_front();
          chk("sw_kind", 32'd1, 32'(e.is_sw));
          chk("sw_clr", ifc.sw_clr, e.val);
        end
      end
      gv_prev = ifc.grant_valid;
    end
  end

  task automatic wait_grant(string name);
    int n;
    n = 0;
    while (!ifc.grant_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk(name, 32'(n < 40), 32'd1);
  endtask

  task automatic service(input logic [1:0] ch, input logic [3:0] dk,
                         input logic [3:0] nd);
    logic [3:0] oh;
    oh = 4'b0001 << ch;
    exp_q.push_back('{is_sw: 1'b0, ch: ch, val: dk});
    exp_q.push_back('{is_sw: 1'b1, ch: ch, val: oh});
    wait_grant("grant_timeout");
    @(negedge clk);
    ifc.xfer_done = 1'b1;
    ifc.dreq = nd;
    @(posedge clk);
    #1;
    chk("hrq_after_done", ifc.hrq, 1'b0);
    chk("gv_after_done", ifc.grant_valid, 1'b0);
    ifc.sw_req = ifc.sw_req & ~ifc.sw_clr;
    @(negedge clk);
    ifc.xfer_done = 1'b0;
  endtask

  task automatic hrq_quiet(string name, int cycles);
    bit seen;
    seen = 1'b0;
    repeat (cycles) begin
      @(negedge clk);
      seen |= ifc.hrq;
    end
    chk(name, seen, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    ifc.dreq = 4'h0;
    ifc.dreq_sense = 1'b0;
    ifc.dack_sense = 1'b0;
    ifc.rotating_pri = 1'b0;
    ifc.ctrl_disable = 1'b0;
    ifc.mask = 4'h0;
    ifc.sw_req = 4'h0;
    ifc.xfer_done = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_hrq", ifc.hrq, 1'b0);
    chk("rst_gv", ifc.grant_valid, 1'b0);
    chk("rst_dack", ifc.dack, 4'hF);
    chk("rst_sw_clr", ifc.sw_clr, 4'h0);
    chk("rst_grant_ch", ifc.grant_ch, 2'd0);
    reset = 1'b0;

    // fixed priority
    ifc.dreq = 4'b1010;
    service(2'd1, 4'b1101, 4'b1000);
    service(2'd3, 4'b0111, 4'b0000);

    // rotating priority, all requests held
    @(negedge clk);
    ifc.rotating_pri = 1'b1;
    ifc.dreq = 4'hF;
    service(2'd0, 4'b1110, 4'hF);
    service(2'd1, 4'b1101, 4'hF);
    service(2'd2, 4'b1011, 4'hF);
    service(2'd3, 4'b0111, 4'hF);
    service(2'd0, 4'b1110, 4'h0);

    // mask and software request
    @(negedge clk);
    ifc.rotating_pri = 1'b0;
    ifc.mask = 4'hF;
    ifc.dreq = 4'hF;
    hrq_quiet("masked_hrq", 8);
    ifc.sw_req = 4'b0100;
    service(2'd2, 4'b1011, 4'hF);
    hrq_quiet("sw_cleared_hrq", 6);
    ifc.dreq = 4'h0;
    repeat (2) @(negedge clk);
    ifc.mask = 4'h0;

    // polarity
    @(negedge clk);
    ifc.dreq_sense = 1'b1;
    ifc.dreq = 4'b1110;
    service(2'd0, 4'b1110, 4'hF);
    @(negedge clk);
    ifc.dack_sense = 1'b1;
    #1;
    chk("dack_idle_hi", ifc.dack, 4'h0);
    ifc.dreq = 4'b1110;
    service(2'd0, 4'b0001, 4'hF);
    chk("dack_after_hi", ifc.dack, 4'h0);
    @(negedge clk);
    ifc.dreq_sense = 1'b0;
    ifc.dreq = 4'h0;
    ifc.dack_sense = 1'b0;

    // abort: hlda drops mid-grant, pointer must not move
    @(negedge clk);
    ifc.rotating_pri = 1'b1;
    ifc.dreq = 4'b0010;
    service(2'd1, 4'b1101, 4'h0);
    @(negedge clk);
    ifc.dreq = 4'hF;
    exp_q.push_back('{is_sw: 1'b0, ch: 2'd2, val: 4'b1011});
    wait_grant("abort_grant_timeout");
    @(negedge clk);
    auto_hlda = 1'b0;
    man_hlda = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("abort_gv", ifc.grant_valid, 1'b0);
    chk("abort_hrq", ifc.hrq, 1'b0);
    chk("abort_dack", ifc.dack, 4'hF);
    @(negedge clk);
    auto_hlda = 1'b1;
    service(2'd2, 4'b1011, 4'h0);

    // disable while requesting; grant_ch tracks the winner in REQ
    @(negedge clk);
    auto_hlda = 1'b0;
    man_hlda = 1'b0;
    ifc.dreq = 4'b0100;
    n = 0;
    while (!ifc.hrq && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("req_seen", 32'(n < 20), 32'd1);
    chk("req_ch", ifc.grant_ch, 2'd2);
    ifc.dreq = 4'b0110;
    repeat (2) @(negedge clk);
    chk("req_track", ifc.grant_ch, 2'd1);
    chk("req_gv", ifc.grant_valid, 1'b0);
    ifc.ctrl_disable = 1'b1;
    @(posedge clk);
    #1;
    chk("disable_hrq", ifc.hrq, 1'b0);
    hrq_quiet("disabled_hrq", 4);
    ifc.dreq = 4'h0;
    repeat (2) @(negedge clk);
    ifc.ctrl_disable = 1'b0;
    auto_hlda = 1'b1;

    // reset in GRANT
    @(negedge clk);
    ifc.dreq = 4'hF;
    exp_q.push_back('{is_sw: 1'b0, ch: 2'd3, val: 4'b0111});
    wait_grant("rst_grant_timeout");
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_hrq", ifc.hrq, 1'b0);
    chk("mid_rst_gv", ifc.grant_valid, 1'b0);
    chk("mid_rst_dack", ifc.dack, 4'hF);
    chk("mid_rst_sw_clr", ifc.sw_clr, 4'h0);
    @(negedge clk);
    reset = 1'b0;
    service(2'd0, 4'b1110, 4'h0);

    repeat (5) @(negedge clk);
    chk("queue_empty", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
